// File: rtl/pi_est_pkg.sv
// Shared constants and FSM encoding for the pi tally scanner.
// The default scan square and circle radius are 480 pixels.
package pi_est_pkg;

  localparam int SIDE    = 480;
  localparam int RADIUS  = 480;
  localparam int CNT_W   = 18;
  localparam int Q_W     = 16;
  localparam int COORD_W = 9;
  localparam int SUM_W   = 19;
  localparam int NUM_W   = CNT_W + Q_W - 1;

  localparam logic [SUM_W-1:0] RADIUS_SQ = 19'd230400;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DRAIN,
    ST_DIV,
    ST_DONE
  } state_t;

endpackage

// File: rtl/pi_tally_scanner_div.sv
// Unsigned restoring divider: one quotient bit per cycle.
// The start cycle computes the first bit directly from num.
module seq_divider #(
  parameter int N_W = 33,
  parameter int D_W = 18,
  parameter int Q_W = 16
) (
  input  logic           clk10,
  input  logic           reset,
  input  logic           start,
  input  logic [N_W-1:0] num,
  input  logic [D_W-1:0] den,
  output logic           busy,
  output logic           done,
  output logic [Q_W-1:0] quot
);

  localparam int C_W = $clog2(Q_W + 1);

  logic [D_W-1:0] rem_r;
  logic [Q_W-1:0] num_sh_r;
  logic [C_W-1:0] cnt_r;
  logic [D_W-1:0] cur_rem_s;
  logic           cur_bit_s;
  logic [D_W:0]   trial_s;
  logic           q_bit_s;
  logic [D_W-1:0] rem_next_s;

  // One restoring step; the upper numerator bits seed the remainder because the quotient fits Q_W
  always_comb begin
    cur_rem_s  = rem_r;
    cur_bit_s  = num_sh_r[Q_W-1];
    q_bit_s    = 1'b0;
    rem_next_s = rem_r;
    if (start && !busy) begin
      cur_rem_s = D_W'(num[N_W-1:Q_W]);
      cur_bit_s = num[Q_W-1];
    end else begin
      cur_rem_s = rem_r;
      cur_bit_s = num_sh_r[Q_W-1];
    end
    trial_s = {cur_rem_s, cur_bit_s};
    if (trial_s >= {1'b0, den}) begin
      q_bit_s    = 1'b1;
      rem_next_s = D_W'(trial_s - {1'b0, den});
    end else begin
      q_bit_s    = 1'b0;
      rem_next_s = trial_s[D_W-1:0];
    end
  end

  // Iteration control, shift registers and completion pulse
  always_ff @(posedge clk10) begin
    if (reset) begin
      rem_r    <= '0;
      num_sh_r <= '0;
      cnt_r    <= '0;
      quot     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (busy) begin
        rem_r    <= rem_next_s;
        num_sh_r <= {num_sh_r[Q_W-2:0], 1'b0};
        quot     <= {quot[Q_W-2:0], q_bit_s};
        cnt_r    <= cnt_r - C_W'(1);
        if (cnt_r == C_W'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          busy <= 1'b1;
        end
      end else if (start) begin
        rem_r    <= rem_next_s;
        num_sh_r <= {num[Q_W-2:0], 1'b0};
        quot     <= {{(Q_W-1){1'b0}}, q_bit_s};
        cnt_r    <= C_W'(Q_W - 1);
        busy     <= 1'b1;
      end else begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pi_tally_scanner.sv
// Raster-scans the pixel memory, tallies set pixels in the square and the quarter
// circle, then divides to a Q3.13 pi estimate.
module pi_tally_scanner
  import pi_est_pkg::*;
#(
  parameter int SCAN_SIDE   = SIDE,
  parameter int SCAN_RADIUS = RADIUS,
  parameter int RD_LAT      = 1
) (
  input  logic               clk10,
  input  logic               reset,
  input  logic               start,
  output logic               rd_en,
  output logic [COORD_W-1:0] rd_x,
  output logic [COORD_W-1:0] rd_y,
  input  logic               rd_color,
  output logic               busy,
  output logic               done,
  output logic               valid,
  output logic [CNT_W-1:0]   total_cnt,
  output logic [CNT_W-1:0]   inside_cnt,
  output logic [Q_W-1:0]     pi_q
);

  localparam logic [COORD_W-1:0] LAST_COORD = COORD_W'(SCAN_SIDE - 1);
  localparam logic [SUM_W-1:0]   RAD_SQ     = SUM_W'(SCAN_RADIUS * SCAN_RADIUS);

  state_t             state_r;
  logic [1:0]         drain_cnt_r;
  logic               div_start_r;
  logic               div_busy_s;
  logic               div_done_s;
  logic [Q_W-1:0]     div_quot_s;
  logic [NUM_W-1:0]   div_num_s;
  logic [SUM_W-1:0]   x_ext_s;
  logic [SUM_W-1:0]   y_ext_s;
  logic [SUM_W-1:0]   radius_sum_s;
  logic               in_flag_s;
  logic [RD_LAT-1:0]  tag_r;
  logic [RD_LAT-1:0]  flag_r;
  logic               hit_s;
  logic               hit_inside_s;

  // Circle test on the address being issued, plus the return-side hit qualifiers
  always_comb begin
    x_ext_s      = {{(SUM_W-COORD_W){1'b0}}, rd_x};
    y_ext_s      = {{(SUM_W-COORD_W){1'b0}}, rd_y};
    radius_sum_s = x_ext_s * x_ext_s + y_ext_s * y_ext_s;
    in_flag_s    = (radius_sum_s < RAD_SQ);
    hit_s        = tag_r[RD_LAT-1] & rd_color;
    hit_inside_s = hit_s & flag_r[RD_LAT-1];
    div_num_s    = {inside_cnt, {(Q_W-1){1'b0}}};
  end

  // Delay the inside flag alongside the read tag so both meet the returning pixel
  always_ff @(posedge clk10) begin
    if (reset) begin
      tag_r  <= '0;
      flag_r <= '0;
    end else begin
      tag_r[0]  <= rd_en;
      flag_r[0] <= in_flag_s;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_r[i]  <= tag_r[i-1];
        flag_r[i] <= flag_r[i-1];
      end
    end
  end

  seq_divider #(
    .N_W(NUM_W),
    .D_W(CNT_W),
    .Q_W(Q_W)
  ) u_div (
    .clk10 (clk10),
    .reset (reset),
    .start (div_start_r),
    .num   (div_num_s),
    .den   (total_cnt),
    .busy  (div_busy_s),
    .done  (div_done_s),
    .quot  (div_quot_s)
  );

  // Control FSM with address generation, accumulation and result registers
  always_ff @(posedge clk10) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      drain_cnt_r <= 2'd0;
      div_start_r <= 1'b0;
      rd_en       <= 1'b0;
      rd_x        <= '0;
      rd_y        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      valid       <= 1'b0;
      total_cnt   <= '0;
      inside_cnt  <= '0;
      pi_q        <= '0;
    end else begin
      done        <= 1'b0;
      div_start_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r    <= ST_SCAN;
            busy       <= 1'b1;
            valid      <= 1'b0;
            total_cnt  <= '0;
            inside_cnt <= '0;
            pi_q       <= '0;
            rd_en      <= 1'b1;
            rd_x       <= '0;
            rd_y       <= '0;
          end
        end
        ST_SCAN: begin
          total_cnt  <= total_cnt + {{(CNT_W-1){1'b0}}, hit_s};
          inside_cnt <= inside_cnt + {{(CNT_W-1){1'b0}}, hit_inside_s};
          if (rd_x == LAST_COORD) begin
            rd_x <= '0;
            if (rd_y == LAST_COORD) begin
              rd_y        <= '0;
              rd_en       <= 1'b0;
              drain_cnt_r <= 2'(RD_LAT - 1);
              state_r     <= ST_DRAIN;
            end else begin
              rd_y <= rd_y + 9'd1;
            end
          end else begin
            rd_x <= rd_x + 9'd1;
          end
        end
        ST_DRAIN: begin
          total_cnt  <= total_cnt + {{(CNT_W-1){1'b0}}, hit_s};
          inside_cnt <= inside_cnt + {{(CNT_W-1){1'b0}}, hit_inside_s};
          if (drain_cnt_r == 2'd0) begin
            state_r     <= ST_DIV;
            div_start_r <= 1'b1;
          end else begin
            drain_cnt_r <= drain_cnt_r - 2'd1;
          end
        end
        ST_DIV: begin
          // An empty square has no meaningful ratio; report zero rather than the divider output
          if (div_done_s && !div_busy_s) begin
            state_r <= ST_DONE;
            done    <= 1'b1;
            valid   <= 1'b1;
            busy    <= 1'b0;
            pi_q    <= (total_cnt == '0) ? '0 : div_quot_s;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pi_tally_scanner.sv
// Self-checking bench: table of pixel patterns, random memories against a
// pixel-count model, and multi-cycle corner cases (restart while busy, reset mid-scan).
module tb_pi_tally_scanner;

  localparam int TB_SIDE = 65;
  localparam int TB_RAD  = 65;
  localparam int TB_LAT  = 2;
  localparam int TB_QW   = 16;
  localparam int NPIX    = TB_SIDE * TB_SIDE;
  localparam int EXP_LAT = NPIX + TB_LAT + 1 + TB_QW + 1;
  localparam int LIMIT   = NPIX + 300;

  logic        clk10 = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        rd_en;
  logic [8:0]  rd_x;
  logic [8:0]  rd_y;
  logic        rd_color;
  logic        busy;
  logic        done;
  logic        valid;
  logic [17:0] total_cnt;
  logic [17:0] inside_cnt;
  logic [15:0] pi_q;

  pi_tally_scanner #(
    .SCAN_SIDE   (TB_SIDE),
    .SCAN_RADIUS (TB_RAD),
    .RD_LAT      (TB_LAT)
  ) dut (
    .clk10      (clk10),
    .reset      (reset),
    .start      (start),
    .rd_en      (rd_en),
    .rd_x       (rd_x),
    .rd_y       (rd_y),
    .rd_color   (rd_color),
    .busy       (busy),
    .done       (done),
    .valid      (valid),
    .total_cnt  (total_cnt),
    .inside_cnt (inside_cnt),
    .pi_q       (pi_q)
  );

  always #5 clk10 = ~clk10;

  // Pixel memory with a fixed read latency
  bit                mem [NPIX];
  logic [TB_LAT-1:0] lat_pipe = '0;
  always @(posedge clk10) begin
    lat_pipe[0] <= rd_en ? mem[int'(rd_y) * TB_SIDE + int'(rd_x)] : 1'b0;
    for (int i = 1; i < TB_LAT; i++) lat_pipe[i] <= lat_pipe[i-1];
  end
  assign rd_color = lat_pipe[TB_LAT-1];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference: count set pixels and those strictly inside the circle, then scale the ratio
  task automatic model(output longint t, output longint ins, output longint pq);
    t = 0;
    ins = 0;
    for (int y = 0; y < TB_SIDE; y++)
      for (int x = 0; x < TB_SIDE; x++)
        if (mem[y * TB_SIDE + x]) begin
          t++;
          if (x * x + y * y < TB_RAD * TB_RAD) ins++;
        end
    pq = (t == 0) ? 0 : (ins * 32768) / t;
  endtask

  task automatic fill(input int pct);
    for (int i = 0; i < NPIX; i++) mem[i] = ($urandom_range(0, 99) < pct);
  endtask

  task automatic set_pix(input int x, input int y);
    if (x >= 0 && y >= 0) mem[y * TB_SIDE + x] = 1'b1;
  endtask

  int     r_lat, r_ndone;
  longint r_total, r_inside, r_pi, r_valid, r_busy;

  // Pulse start, optionally pulse it again at scan cycle restart_at, and capture outputs at done
  task automatic run_scan(input int restart_at);
    r_lat = 0;
    r_ndone = 0;
    @(negedge clk10);
    start = 1'b1;
    @(posedge clk10);
    #1;
    start = 1'b0;
    r_lat = 1;
    while (!done && r_lat < LIMIT) begin
      start = (r_lat == restart_at);
      @(posedge clk10);
      #1;
      r_lat++;
    end
    start = 1'b0;
    if (done) r_ndone = 1;
    else $display("FAIL timeout: no done within %0d cycles", LIMIT);
    r_total  = total_cnt;
    r_inside = inside_cnt;
    r_pi     = pi_q;
    r_valid  = valid;
    r_busy   = busy;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk10);
      #1;
      if (done) r_ndone++;
    end
  endtask

  typedef struct {
    string name;
    int x0, y0, x1, y1, x2, y2;
    int e_total, e_inside, e_pi;
  } vec_t;

  vec_t   vecs[6];
  longint m_t, m_i, m_p;
  int     n_done_rst;

  initial begin
    vecs[0] = '{"empty",      -1, -1, -1, -1, -1, -1, 0, 0, 0};
    vecs[1] = '{"origin",      0,  0, -1, -1, -1, -1, 1, 1, 32768};
    vecs[2] = '{"far_corner", 64, 64, -1, -1, -1, -1, 1, 0, 0};
    vecs[3] = '{"on_radius",  39, 52, -1, -1, -1, -1, 1, 0, 0};
    vecs[4] = '{"diag_pair",  45, 45, 46, 46, -1, -1, 2, 1, 16384};
    vecs[5] = '{"edges",       0, 64, 64,  0, 64, 64, 3, 2, 21845};

    repeat (3) @(posedge clk10);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", valid, 0);
    chk("rst_total", total_cnt, 0);
    chk("rst_inside", inside_cnt, 0);
    chk("rst_pi", pi_q, 0);
    chk("rst_rd_xy", {rd_x, rd_y}, 0);

    // Start asserted together with reset must not launch a scan
    @(negedge clk10);
    start = 1'b1;
    @(posedge clk10);
    #1;
    chk("rst_start_busy", busy, 0);
    chk("rst_start_rd_en", rd_en, 0);
    @(negedge clk10);
    start = 1'b0;
    reset = 1'b0;
    @(posedge clk10);
    #1;
    chk("rst_start_after", busy, 0);

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < NPIX; i++) mem[i] = 1'b0;
      set_pix(vecs[v].x0, vecs[v].y0);
      set_pix(vecs[v].x1, vecs[v].y1);
      set_pix(vecs[v].x2, vecs[v].y2);
      run_scan(-1);
      chk({vecs[v].name, "_latency"}, r_lat, EXP_LAT);
      chk({vecs[v].name, "_total"}, r_total, vecs[v].e_total);
      chk({vecs[v].name, "_inside"}, r_inside, vecs[v].e_inside);
      chk({vecs[v].name, "_pi"}, r_pi, vecs[v].e_pi);
      chk({vecs[v].name, "_valid"}, r_valid, 1);
      chk({vecs[v].name, "_busy_low"}, r_busy, 0);
      chk({vecs[v].name, "_done_pulses"}, r_ndone, 1);
      chk({vecs[v].name, "_hold_total"}, total_cnt, vecs[v].e_total);
    end

    // Full square, then the same with a stray start mid-scan
    for (int i = 0; i < NPIX; i++) mem[i] = 1'b1;
    model(m_t, m_i, m_p);
    for (int k = 0; k < 2; k++) begin
      run_scan(k == 0 ? -1 : 1000);
      chk(k == 0 ? "full_total" : "restart_total", r_total, m_t);
      chk(k == 0 ? "full_inside" : "restart_inside", r_inside, m_i);
      chk(k == 0 ? "full_pi" : "restart_pi", r_pi, m_p);
      chk(k == 0 ? "full_latency" : "restart_latency", r_lat, EXP_LAT);
      chk(k == 0 ? "full_done_pulses" : "restart_done_pulses", r_ndone, 1);
    end

    for (int k = 0; k < 2; k++) begin
      fill(k == 0 ? 30 : 75);
      model(m_t, m_i, m_p);
      run_scan(-1);
      chk("rand_total", r_total, m_t);
      chk("rand_inside", r_inside, m_i);
      chk("rand_pi", r_pi, m_p);
      chk("rand_valid", r_valid, 1);
    end

    // Reset part-way through a scan
    fill(50);
    @(negedge clk10);
    start = 1'b1;
    @(posedge clk10);
    #1;
    start = 1'b0;
    repeat (2000) @(posedge clk10);
    @(negedge clk10);
    reset = 1'b1;
    @(posedge clk10);
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_rd_en", rd_en, 0);
    chk("midrst_total", total_cnt, 0);
    chk("midrst_inside", inside_cnt, 0);
    chk("midrst_valid", valid, 0);
    chk("midrst_done", done, 0);
    @(negedge clk10);
    reset = 1'b0;
    n_done_rst = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk10);
      #1;
      if (done) n_done_rst++;
    end
    chk("midrst_no_done", n_done_rst, 0);
    model(m_t, m_i, m_p);
    run_scan(-1);
    chk("after_rst_total", r_total, m_t);
    chk("after_rst_inside", r_inside, m_i);
    chk("after_rst_pi", r_pi, m_p);
    chk("after_rst_latency", r_lat, EXP_LAT);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
